// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: widths, memory aluop codes
// and the bus-access FSM state encoding.
package mem_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int WriteBus   = 4;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational data path for the MEM stage: decode of memory ops, alignment
// check, byte enables, store replication and load extract/extend.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [7:0]    i_aluop,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_reg2,
  input  logic [DW-1:0] i_rdata,
  output logic          o_is_load,
  output logic          o_is_store,
  output logic          o_misaligned,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_load_data
);

  logic [1:0]    w_ofs;
  logic [DW-1:0] w_byte_shift;
  logic [DW-1:0] w_half_shift;

  assign w_ofs        = i_addr[1:0];
  // Lane of interest moved down to bit 0 before extension
  assign w_byte_shift = i_rdata >> {w_ofs, 3'b000};
  assign w_half_shift = i_rdata >> {w_ofs[1], 4'b0000};

  always_comb begin
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_misaligned = 1'b0;
    o_be         = 4'b0000;
    o_wdata      = ZeroWord;
    o_load_data  = ZeroWord;
    unique case (i_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        o_is_load   = 1'b1;
        o_be        = 4'b0001 << w_ofs;
        o_load_data = (i_aluop == EXE_LB_OP)
                    ? {{(DW-8){w_byte_shift[7]}}, w_byte_shift[7:0]}
                    : {{(DW-8){1'b0}}, w_byte_shift[7:0]};
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        o_is_load    = 1'b1;
        o_misaligned = w_ofs[0];
        o_be         = w_ofs[1] ? 4'b1100 : 4'b0011;
        o_load_data  = (i_aluop == EXE_LH_OP)
                     ? {{(DW-16){w_half_shift[15]}}, w_half_shift[15:0]}
                     : {{(DW-16){1'b0}}, w_half_shift[15:0]};
      end
      EXE_LW_OP: begin
        o_is_load    = 1'b1;
        o_misaligned = (w_ofs != 2'b00);
        o_be         = 4'b1111;
        o_load_data  = i_rdata;
      end
      EXE_SB_OP: begin
        o_is_store = 1'b1;
        o_be       = 4'b0001 << w_ofs;
        o_wdata    = {(DW/8){i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_is_store   = 1'b1;
        o_misaligned = w_ofs[0];
        o_be         = w_ofs[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {(DW/16){i_reg2[15:0]}};
      end
      EXE_SW_OP: begin
        o_is_store   = 1'b1;
        o_misaligned = (w_ofs != 2'b00);
        o_be         = 4'b1111;
        o_wdata      = i_reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack bus, stalls the
// pipeline while an access is outstanding and forms the MEM/WB fields.
//
//   state   | meaning
//   IDLE    | evaluating the op from EX/MEM; zero-wait ack completes here
//   WAIT    | request outstanding, pipeline frozen, timeout counter running
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic [WriteBus-1:0]   mem_wreg,
  input  logic [DW-1:0]         mem_wdata,
  input  logic [7:0]            mem_aluop,
  input  logic [DW-1:0]         mem_mem_addr,
  input  logic [DW-1:0]         mem_reg2,
  input  logic [DW-1:0]         mem_pc,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [DW-1:0]         dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [DW-1:0]         dbus_wdata,
  input  logic [DW-1:0]         dbus_rdata,
  input  logic                  dbus_ack,
  output logic                  stall_req,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic [WriteBus-1:0]   wb_wreg,
  output logic [DW-1:0]         wb_wdata,
  output logic                  addr_err,
  output logic [DW-1:0]         err_badvaddr,
  output logic [DW-1:0]         err_pc
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;

  logic          w_is_load;
  logic          w_is_store;
  logic          w_misaligned;
  logic [3:0]    w_be;
  logic [DW-1:0] w_st_data;
  logic [DW-1:0] w_ld_data;

  mem_align #(.DW(DW)) u_align (
    .i_aluop      (mem_aluop),
    .i_addr       (mem_mem_addr),
    .i_reg2       (mem_reg2),
    .i_rdata      (dbus_rdata),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_st_data),
    .o_load_data  (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    dbus_req     = 1'b0;
    stall_req    = 1'b0;
    addr_err     = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;

    if (!rst) begin
      // Outputs go quiet as soon as reset asserts, not at the next edge
      wb_wd       = '0;
      wb_wreg     = '0;
      wb_wdata    = ZeroWord;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else if (w_is_load || w_is_store) begin
      if (w_is_load) wb_wdata = w_ld_data;
      wb_wreg = w_is_load ? 4'b1111 : 4'b0000;
      if (w_misaligned) begin
        wb_wreg     = 4'b0000;
        addr_err    = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        dbus_req = 1'b1;
        if (dbus_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          wb_wreg = 4'b0000;
          if (r_state == ST_IDLE) begin
            stall_req   = 1'b1;
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt == CNT_LAST) begin
            dbus_req    = 1'b0;
            addr_err    = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            stall_req = 1'b1;
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Bus qualifiers only meaningful while a request is driven
  assign dbus_we      = dbus_req & w_is_store;
  assign dbus_be      = dbus_req ? w_be : 4'b0000;
  assign dbus_addr    = rst ? {mem_mem_addr[DW-1:2], 2'b00} : ZeroWord;
  assign dbus_wdata   = rst ? w_st_data : ZeroWord;
  assign err_badvaddr = addr_err ? mem_mem_addr : ZeroWord;
  assign err_pc       = addr_err ? mem_pc : ZeroWord;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the registered EX/MEM outputs and performs loads and stores over a req/ack data bus.
- Aligns load data, replicates store data and generates byte enables.
- Requests a pipeline stall while a bus access is outstanding.
- Produces write-back fields for the MEM/WB register.

Parameters:
- DW, 32, data/address width (matches RegBus)
- TIMEOUT, 255, WAIT cycles without ack before forced abort

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mem_wd  in  5  destination register address
- mem_wreg  in  4  register byte write enables from EX
- mem_wdata  in  32  ALU result
- mem_aluop  in  8  operation code
- mem_mem_addr  in  32  effective address
- mem_reg2  in  32  store source data
- mem_pc  in  32  instruction PC
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word address; bits [1:0] always 0
- dbus_be  out  4  byte lane enables
- dbus_wdata  out  32  store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  access complete
- stall_req  out  1  freeze EX/MEM and earlier stages
- wb_wd  out  5  to MEM/WB
- wb_wreg  out  4  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- addr_err  out  1  misaligned or timeout, one-cycle pulse
- err_badvaddr  out  32  faulting address
- err_pc  out  32  faulting PC

Behaviour:
- Byte order is little-endian: byte k (k = addr[1:0]) occupies bits 8k+7:8k.
- Memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW. Any other aluop passes through: wb_* = mem_wd/mem_wreg/mem_wdata, no bus activity, stall_req=0.
- Alignment checks are combinational on mem_mem_addr:
  - LH/LHU/SH fault when addr[0]=1.
  - LW/SW fault when addr[1:0]≠0.
  - On fault: no request, wb_wreg=0, addr_err=1 for that cycle, err_badvaddr=addr, err_pc=mem_pc.
- Store byte enables and data:
  - SB: be=1<<addr[1:0], byte replicated ×4.
  - SH: be=4'b0011 or 4'b1100 by addr[1], halfword replicated ×2.
  - SW: be=4'b1111.
  - Stores force wb_wreg=0.
- Load byte enables match the store rules for the same size. Load result is extracted from dbus_rdata using addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - Loads write wb_wreg=4'b1111.
- FSM with states IDLE and WAIT; the counter is 8 bits.
  - IDLE:
    - An aligned memory op drives dbus_req=1 combinationally with the computed addr/be/we/wdata.
    - ack in the same cycle: zero-wait completion, stall_req=0, wb_* valid, stay in IDLE.
    - No ack: stall_req=1, wb_wreg=0 (bubble), next state WAIT, counter cleared.
  - WAIT:
    - dbus_req stays 1 and addr/be/we/wdata stay stable; the inputs are frozen by the stall.
    - stall_req=1 until ack.
    - ack cycle: stall_req=0, wb_* valid using the same-cycle dbus_rdata, next state IDLE.
    - No ack: counter increments.
    - Counter reaching TIMEOUT: drop req, addr_err pulse, wb_wreg=0, stall_req=0, next state IDLE.
  - dbus_ack with dbus_req=0 is ignored.
- Back-to-back memory ops: after completion in WAIT, the new op from EX/MEM is evaluated in IDLE the following cycle. There is no dead cycle beyond that.
- Reset (asynchronous, active-low), including mid-WAIT:
  - FSM=IDLE, counter=0.
  - dbus_req=0, dbus_we=0, dbus_be=0.
  - stall_req=0, addr_err=0.
  - wb_wd=0, wb_wreg=0, wb_wdata=0.
  - A pending bus transaction is abandoned. A late ack after reset release is ignored (IDLE with no req).
- All wb_*/dbus_* outputs are combinational from state plus inputs. Only FSM state and counter are registers.

Decomposition:
- Shared defines package holds:
  - aluop codes for LB..SW
  - RegBus, RegAddrBus, WriteBus widths
  - ZeroWord
  - FSM state encodings IDLE=1'b0, WAIT=1'b1
- One natural sub-module: mem_align. It is combinational and handles byte-enable/store-data generation, load extract/extend and the misalignment check. The FSM stays in mem_stage.

Test Plan:
- ADD passthrough: wd=5, wreg=4'hF, wdata=0x1234 → wb_* identical, dbus_req=0, stall_req=0.
- LB, addr 0x1003, rdata 0x80AABBCC, ack same cycle → dbus_addr=0x1000, be=4'b1000, wb_wdata=0xFFFFFF80, wreg=4'hF, no stall.
- SH, addr 0x2002, reg2=0x0000BEEF, ack after 3 cycles → be=4'b1100, wdata=0xBEEFBEEF, stall_req high exactly 3 cycles, wb_wreg=0.
- LW, addr 0x3001 → no req, addr_err pulse, err_badvaddr=0x3001, err_pc=mem_pc, wb_wreg=0.
- LHU, addr 0x4002, no ack → req held; rst low on wait-cycle 2 → req=0, stall=0 immediately; a late ack after release is ignored.
- TIMEOUT=4, LW with no ack → addr_err on the 4th WAIT cycle, then return to IDLE with stall_req=0.
